// File: rtl/fifo_arb_pkg.sv
// Shared types for the packet-locked FIFO write arbiter: FSM state encoding
// and the grant index width derived from the requester count.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int id_width(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority selector: combinational, zero latency, no backpressure.
// Search starts one past last_grant and wraps, so the previous winner ranks last.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    int  idx;
    logic found;

    assign any_req = |req;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin writer into a FIFO: one arbitration cycle, then data passes with zero latency.
// fifo_full stalls the owner (ready and push drop); the grant is held until the owner's last beat is accepted.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [WIDTH-1:0]          fifo_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int IDW = id_width(NREQ);

    arb_state_e       state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             any_req;
    logic             accept;
    logic             last_beat;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign busy      = (state == GRANT);
    assign accept    = busy && req_valid[grant_id] && !fifo_full;
    assign last_beat = accept && req_last[grant_id];
    assign fifo_push = accept;
    assign fifo_data = req_data[grant_id*WIDTH +: WIDTH];

    // Only the owner sees ready; it tracks fifo_full even while the owner is idle.
    always_comb begin
        req_ready = '0;
        if (busy && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (last_beat) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width, matching the FIFO data_i width.
REQ-002 The block SHALL have parameter NREQ, default 4, the number of requesters (2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester beat valid.
REQ-006 The block SHALL have port req_last, input, NREQ bits: per-requester "this beat ends packet".
REQ-007 The block SHALL have port req_data, input, NREQ*WIDTH bits: requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: beat accepted from requester i when req_valid[i] && req_ready[i].
REQ-009 The block SHALL have port fifo_full, input, 1 bit: FIFO full flag.
REQ-010 The block SHALL have port fifo_push, output, 1 bit: FIFO push strobe.
REQ-011 The block SHALL have port fifo_data, output, WIDTH bits: FIFO write data.
REQ-012 The block SHALL have port grant_id, output, $clog2(NREQ) bits: index of the current owner.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-014 The block SHALL implement an FSM with two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid bit high, the block SHALL select one requester round-robin, register it in grant_id and enter GRANT on the next edge, giving one cycle of arbitration latency.
REQ-016 Round-robin priority SHALL start at (last_grant+1) mod NREQ and wrap through the indices; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-017 In IDLE, req_ready and fifo_push SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal ~fifo_full, and all other req_ready bits SHALL be 0 (combinational).
REQ-019 fifo_push SHALL equal busy && req_valid[grant_id] && ~fifo_full, so no push is ever issued while full.
REQ-020 fifo_data SHALL equal req_data slice grant_id (combinational mux), with zero added latency.
REQ-021 Grant SHALL be locked for the whole packet: the owner is not changed until an accepted beat has req_last[grant_id]=1.
REQ-022 On an accepted last beat, the block SHALL load last_grant with grant_id and return to IDLE, leaving one bubble cycle between packets.
REQ-023 If the owner drops req_valid mid-packet, the block SHALL stay in GRANT with no timeout.
REQ-024 If fifo_full is asserted mid-packet, the block SHALL stall with no push and the state held.
REQ-025 A single-beat packet (valid and last together) SHALL be accepted in one GRANT cycle.
REQ-026 Requests from non-owners SHALL be ignored; their req_valid is held by the requester.
REQ-027 Assertions of req_last by non-owners, or of req_last without req_valid, SHALL have no effect.

Reset
REQ-028 On rst=1, the block SHALL asynchronously reset: state to IDLE, grant_id 0, last_grant NREQ-1, busy 0, req_ready 0, fifo_push 0.
REQ-029 A reset asserted mid-packet SHALL abort the packet with no further push; beats already pushed remain in the FIFO.
REQ-030 After rst deasserts, arbitration SHALL resume from IDLE on the first clk edge.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and a function computing the id width from NREQ.
REQ-032 A combinational sub-module rr_arbiter (inputs: request vector and last_grant; outputs: winner index and any_req) SHALL perform the rotate-priority selection.
REQ-033 fifo_wr_arbiter SHALL own the FSM, the lock and the muxing.

Verification
REQ-034 Scenario: after reset, req_valid=4'b1111, each requester sends a 1-beat packet, fifo_full=0 -> grants in order 0,1,2,3, one push every 2 cycles.
REQ-035 Scenario: req 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3 with last on 0xA3) while req 1 is valid -> three consecutive pushes of A1/A2/A3 with grant_id=2, then req 1 is granted.
REQ-036 Scenario: fifo_full=1 for 3 cycles mid-packet -> fifo_push=0 and req_ready=0 during those cycles; the packet resumes without loss or duplication.
REQ-037 Scenario: the owner drops valid for 2 cycles mid-packet while req 0 is valid -> grant_id is unchanged and req 0 is not served until the owner's last beat.
REQ-038 Scenario: async rst pulse mid-packet, not aligned to clk -> busy, fifo_push and req_ready go to 0 immediately; the next grant goes to req 0.
REQ-039 Scenario: NREQ=4, last_grant=3 wraps, only req 3 valid -> req 3 is granted again, with no starvation check failure.
